stream_arb_mux: RTL

//   N-channel, W-bit registered stream multiplexer with valid/ready handshakes and

---
 rtl/bridge_mux_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 54 +++++
 rtl/stream_arb_mux.sv | 84 ++++++++
 3 files changed

// File: rtl/bridge_mux_pkg.sv
// Shared types and helpers for the stream arbitration multiplexer.
package bridge_mux_pkg;

  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

  // A single channel still needs a 1-bit select so that port widths stay legal.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot arbiter: fixed priority (lowest index) or round-robin from a rotating pointer.
module rr_arbiter
  import bridge_mux_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  parameter int  ARB_MODE = 1,
  localparam int SEL_W    = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] grant,
  output logic [SEL_W-1:0]  grant_idx
);

  localparam bit USE_RR = (ARB_MODE == int'(ARB_RR)) && (NUM_CH > 1);

  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_start;
  logic             w_found;

  assign w_start = USE_RR ? r_ptr : '0;

  // Two passes: first the channels at or above the pointer, then the wrapped ones below it.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en && !w_found && req[i] && (i >= int'(w_start))) begin
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
        w_found   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (en && !w_found && req[i] && (i < int'(w_start))) begin
        grant[i]  = 1'b1;
        grant_idx = SEL_W'(i);
        w_found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (USE_RR && en && (|req)) begin
      r_ptr <= (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-channel registered stream multiplexer with built-in arbitration and valid/ready handshakes.
module stream_arb_mux
  import bridge_mux_pkg::*;
#(
  parameter int  NUM_CH   = 4,
  parameter int  DATA_W   = 32,
  parameter int  ARB_MODE = 1,
  localparam int SEL_W    = sel_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);

  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [SEL_W-1:0]  r_out_sel;

  logic              w_load_en;
  logic              w_arb_en;
  logic [NUM_CH-1:0] w_grant;
  logic [SEL_W-1:0]  w_grant_idx;
  logic [DATA_W-1:0] w_mux_data;
  logic [DATA_W-1:0] w_ch_data [NUM_CH];

  assign w_load_en = !r_out_valid || out_ready;
  // Reset blocks all acceptance so nothing is lost while the register is being cleared.
  assign w_arb_en  = w_load_en && !rst;

  rr_arbiter #(
    .NUM_CH   (NUM_CH),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (in_valid),
    .en        (w_arb_en),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign in_ready = w_grant;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign w_ch_data[gi] = in_data[gi*DATA_W +: DATA_W];
  end

  // AND-OR mux on the one-hot grant keeps the select path shallow.
  always_comb begin
    w_mux_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_grant[i]) begin
        w_mux_data = w_mux_data | w_ch_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_load_en) begin
      if (|w_grant) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux_data;
        r_out_sel   <= w_grant_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
